// File: rtl/qrd_feeder_if.sv
// Upstream sample stream into the QRD feeder: one complex sample per transfer,
// accepted on in_valid && in_ready.
interface qrd_feeder_if #(
  parameter int W = 14
) ();
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_r;
  logic signed [W-1:0] in_i;

  modport master (output in_valid, output in_r, output in_i, input in_ready);
  modport slave  (input in_valid, input in_r, input in_i, output in_ready);
endinterface

// File: rtl/qrd_feeder.sv
// Buffers one 4x5 augmented matrix [H | y] and replays it to the QRD core's
// four row ports on the core's fixed staggered schedule.
module qrd_feeder #(
  parameter int W       = 14,
  parameter int RUN_LEN = 108
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  qrd_feeder_if.slave         up_if,
  output logic signed [W-1:0] row_in_1_r_o,
  output logic signed [W-1:0] row_in_1_i_o,
  output logic signed [W-1:0] row_in_2_r_o,
  output logic signed [W-1:0] row_in_2_i_o,
  output logic signed [W-1:0] row_in_3_r_o,
  output logic signed [W-1:0] row_in_3_i_o,
  output logic signed [W-1:0] row_in_4_r_o,
  output logic signed [W-1:0] row_in_4_i_o,
  output logic                row_in_1_f_o,
  output logic                row_in_2_f_o,
  output logic                row_in_3_f_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int NS = 20;
  localparam int TW = $clog2(RUN_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(RUN_LEN - 1);
  localparam logic [TW-1:0] ROW_T0 [4] = '{TW'(0), TW'(1), TW'(21), TW'(41)};

  typedef enum logic {S_LOAD, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [TW-1:0]   t_q, t_d;
  logic [2*W-1:0]  mem_q [NS];
  logic [2*W-1:0]  row_q [4];
  logic [2*W-1:0]  row_d [4];
  logic [2:0]      flag_q, flag_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   off;
  logic [4:0]      idx;
  logic            xfer;

  assign xfer           = up_if.in_valid && ready_q;
  assign up_if.in_ready = ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = t_q;
    if (clr_i) begin
      state_d = S_LOAD;
      count_d = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (xfer) begin
            if (count_q == 5'(NS - 1)) begin
              state_d = S_RUN;
              count_d = '0;
              t_d     = '0;
            end else begin
              count_d = count_q + 5'd1;
            end
          end
        end
        S_RUN: begin
          if (t_q == T_LAST) begin
            state_d = S_LOAD;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Port values are derived from the next state so they land in flops and
  // appear in the same cycle as the matching t.
  always_comb begin
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d == S_RUN);
    done_d  = busy_d && (t_d == T_LAST);
    flag_d  = '0;
    off     = '0;
    idx     = '0;
    for (int n = 0; n < 4; n++) begin
      row_d[n] = '0;
    end
    if (busy_d) begin
      flag_d[0] = (t_d == TW'(0));
      flag_d[1] = (t_d == TW'(2));
      flag_d[2] = (t_d == TW'(23));
      for (int n = 0; n < 4; n++) begin
        if (t_d >= ROW_T0[n] && t_d < ROW_T0[n] + TW'(5)) begin
          off      = t_d - ROW_T0[n];
          idx      = 5'(5 * n) + off[4:0];
          row_d[n] = mem_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !clr_i) begin
      mem_q[count_q] <= {up_if.in_r, up_if.in_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      count_q <= '0;
      t_q     <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= '0;
      row_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      t_q     <= t_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flag_q  <= flag_d;
      row_q   <= row_d;
    end
  end

  assign row_in_1_r_o = row_q[0][2*W-1:W];
  assign row_in_1_i_o = row_q[0][W-1:0];
  assign row_in_2_r_o = row_q[1][2*W-1:W];
  assign row_in_2_i_o = row_q[1][W-1:0];
  assign row_in_3_r_o = row_q[2][2*W-1:W];
  assign row_in_3_i_o = row_q[2][W-1:0];
  assign row_in_4_r_o = row_q[3][2*W-1:W];
  assign row_in_4_i_o = row_q[3][W-1:0];
  assign row_in_1_f_o = flag_q[0];
  assign row_in_2_f_o = flag_q[1];
  assign row_in_3_f_o = flag_q[2];
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_qrd_feeder.sv
// Self-checking bench for qrd_feeder: frames are streamed in and every run
// cycle is compared against a table-driven model of the replay schedule.
module tb_qrd_feeder;

  localparam int W       = 14;
  localparam int RUN_LEN = 108;
  localparam int ROW_T0 [4] = '{0, 1, 21, 41};

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic signed [W-1:0] r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i;
  logic f1, f2, f3, busy, frameDone;

  qrd_feeder_if #(.W(W)) up_if ();

  qrd_feeder #(.W(W), .RUN_LEN(RUN_LEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .up_if        (up_if),
    .row_in_1_r_o (r1r),
    .row_in_1_i_o (r1i),
    .row_in_2_r_o (r2r),
    .row_in_2_i_o (r2i),
    .row_in_3_r_o (r3r),
    .row_in_3_i_o (r3i),
    .row_in_4_r_o (r4r),
    .row_in_4_i_o (r4i),
    .row_in_1_f_o (f1),
    .row_in_2_f_o (f2),
    .row_in_3_f_o (f3),
    .busy_o       (busy),
    .frame_done_o (frameDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCompared   = 0;
  int nMismatched = 0;
  int doneCyc     = -1;

  logic signed [W-1:0] hr [20];
  logic signed [W-1:0] hi [20];

  // Observed port bundle: 4 rows x {r,i}, 3 flags, busy, frame_done, in_ready.
  function automatic logic [117:0] actVec();
    return {r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i, f1, f2, f3, busy, frameDone, up_if.in_ready};
  endfunction

  // Expected bundle at run cycle t, straight from the replay table.
  function automatic logic [117:0] expVec(int t);
    logic [117:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) begin
      if (t >= ROW_T0[n] && t < ROW_T0[n] + 5) begin
        v[117 - 28*n -: 28] = {hr[5*n + t - ROW_T0[n]], hi[5*n + t - ROW_T0[n]]};
      end
    end
    v[5] = (t == 0);
    v[4] = (t == 2);
    v[3] = (t == 23);
    v[2] = 1'b1;
    v[1] = (t == RUN_LEN - 1);
    v[0] = 1'b0;
    return v;
  endfunction

  task automatic fillNominal();
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 5; k++) begin
        hr[5*j + k] = W'(10*j + k);
        hi[5*j + k] = W'(-(10*j + k));
      end
  endtask

  task automatic fillSign();
    for (int e = 0; e < 20; e++) begin
      hr[e] = -14'sd8192;
      hi[e] = 14'sd8191;
    end
  endtask

  task automatic fillRandom();
    for (int e = 0; e < 20; e++) begin
      hr[e] = W'($urandom);
      hi[e] = W'($urandom);
    end
  endtask

  task automatic checkIdle(input string name);
    logic [117:0] a;
    a = actVec();
    nCompared++;
    if (a !== 118'h1) begin
      nMismatched++;
      $display("[TB] FAIL %s idle: got=%h expected=%h", name, a, 118'h1);
    end
  endtask

  // mode 0: continuous valid, 1: toggling, 2: random gaps.
  task automatic driveFrame(input int mode, input bit holdAfter, output int firstX, output int launchCyc);
    int idx = 0;
    int guard = 0;
    bit tog = 1'b0;
    bit v;
    firstX    = -1;
    launchCyc = -1;
    while (idx < 20 && guard < 400) begin
      @(negedge clk);
      guard++;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = ~tog; tog = ~tog; end
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      up_if.in_valid = v;
      up_if.in_r     = hr[idx];
      up_if.in_i     = hi[idx];
      if (v && up_if.in_ready) begin
        if (idx == 0) firstX = cyc;
        if (idx == 19) begin
          nCompared++;
          if (busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL busy_before_launch: got=%b expected=0", busy);
          end
        end
        idx++;
      end
    end
    if (idx < 20) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL load_timeout: got=%0d transfers expected=20", idx);
    end else begin
      @(posedge clk);
      #1;
      up_if.in_valid = holdAfter;
      @(negedge clk);
      launchCyc = cyc;
    end
  endtask

  task automatic checkRun(input int lastT, input string name);
    logic [117:0] a, e;
    for (int t = 0; t <= lastT; t++) begin
      if (t > 0) @(negedge clk);
      if (t == RUN_LEN - 1) doneCyc = cyc;
      a = actVec();
      e = expVec(t);
      nCompared++;
      if (a !== e) begin
        nMismatched++;
        $display("[TB] FAIL %s t=%0d: got=%h expected=%h", name, t, a, e);
      end
    end
  endtask

  task automatic fullFrame(input int mode, input string name);
    int fx, lc;
    driveFrame(mode, 1'b0, fx, lc);
    checkRun(RUN_LEN - 1, name);
    @(negedge clk);
    checkIdle(name);
  endtask

  task automatic test_reset();
    logic [117:0] a;
    rst_n = 1'b0;
    up_if.in_valid = 1'b1;
    up_if.in_r = W'($urandom);
    up_if.in_i = W'($urandom);
    repeat (3) begin
      @(negedge clk);
      a = actVec();
      nCompared++;
      if (a !== '0) begin
        nMismatched++;
        $display("[TB] FAIL reset_hold: got=%h expected=0", a);
      end
    end
    rst_n = 1'b1;
    up_if.in_valid = 1'b0;
    @(negedge clk);
    checkIdle("reset_release");
  endtask

  task automatic test_nominal();
    fillNominal();
    fullFrame(0, "nominal");
  endtask

  task automatic test_sign_width();
    fillSign();
    fullFrame(0, "sign_width");
  endtask

  task automatic test_throttled();
    fillNominal();
    fullFrame(1, "throttled");
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      fillRandom();
      fullFrame(2, "random");
    end
  endtask

  task automatic test_abort();
    int fx, lc;
    fillRandom();
    driveFrame(0, 1'b0, fx, lc);
    checkRun(30, "abort_pre");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkIdle("abort");
    repeat (7) begin
      @(negedge clk);
      up_if.in_valid = 1'b1;
      up_if.in_r = W'($urandom);
      up_if.in_i = W'($urandom);
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    up_if.in_valid = 1'b0;
    checkIdle("clr_drop");
    fillRandom();
    fullFrame(0, "after_abort");
  endtask

  task automatic test_async_reset();
    int fx, lc;
    logic [117:0] a;
    fillRandom();
    driveFrame(0, 1'b0, fx, lc);
    checkRun(50, "async_pre");
    #2;
    rst_n = 1'b0;
    #1;
    a = actVec();
    nCompared++;
    if (a !== '0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: got=%h expected=0", a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("async_release");
    fillRandom();
    fullFrame(2, "after_async");
  endtask

  task automatic test_back_to_back();
    int fx1, lc1, fx2, lc2;
    fillRandom();
    driveFrame(0, 1'b1, fx1, lc1);
    checkRun(RUN_LEN - 1, "b2b_first");
    fillRandom();
    driveFrame(0, 1'b0, fx2, lc2);
    nCompared++;
    if (fx2 !== doneCyc + 1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first_xfer: got=%0d expected=%0d", fx2, doneCyc + 1);
    end
    nCompared++;
    if (lc2 - lc1 !== 20 + RUN_LEN) begin
      nMismatched++;
      $display("[TB] FAIL b2b_period: got=%0d expected=%0d", lc2 - lc1, 20 + RUN_LEN);
    end
    checkRun(RUN_LEN - 1, "b2b_second");
    @(negedge clk);
    checkIdle("b2b_end");
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    up_if.in_valid = 1'b0;
    up_if.in_r = '0;
    up_if.in_i = '0;
    test_reset();
    test_nominal();
    test_sign_width();
    test_throttled();
    test_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/qrd_feeder.md
# qrd_feeder

Input sequencer for the 4x4 complex QRD systolic core. It accepts one augmented matrix [H | y] over a valid/ready stream and buffers all 20 complex samples. It then replays them to the core's four row ports on the fixed staggered schedule the core requires, and flags completion once the core's output window has closed. It sits between the upstream sample source and the QRD core's row_in_* ports.

## Interface
- W, 14, sample width (signed two's complement, real and imag each)
- RUN_LEN, 108, cycles in one core run (t = 0..RUN_LEN-1)
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort; returns to LOAD
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_r, in_i  in  W each  sample; order is row-major, row j = 0..3, column k = 0..4 (k = 4 is y)
- row_in_n_r, row_in_n_i  out  W each (n = 1..4)  core row data
- row_in_1_f, row_in_2_f, row_in_3_f  out  1 each  core row start flags
- busy  out  1  run in progress
- frame_done  out  1  one-cycle pulse at end of run

## Operation
- Buffer: 20 entries of 2W bits, written at index 5*j + k.
- Transfer occurs on in_valid && in_ready.
- States:
  - LOAD: in_ready=1. Each transfer increments the sample count (0..19). When the transfer with count 19 occurs, go to RUN with t=0 and count=0.
  - RUN: in_ready=0, busy=1, t increments each cycle. At t=RUN_LEN-1, frame_done=1 and the next state is LOAD.
- Drive schedule during RUN, shown on the ports in the cycle where t equals the listed value. The buffer element is H[j][k].
  - row 1: t = 0..4 → H[0][t]; row_in_1_f=1 at t=0
  - row 2: t = 1..5 → H[1][t-1]; row_in_2_f=1 at t=2
  - row 3: t = 21..25 → H[2][t-21]; row_in_3_f=1 at t=23
  - row 4: t = 41..45 → H[3][t-41]; no flag
  - Outside these windows, all row data ports and flags drive 0.
- All row ports are registered: their values come from flops, with no combinational path from in_* to row_in_*.
- No arithmetic is performed; samples pass through bit-exact, including the sign.
- clr has priority over everything else. In the cycle after clr=1:
  - state=LOAD, count=0, t=0;
  - all row ports, flags, busy and frame_done are 0;
  - in_ready=1;
  - buffer contents are don't-care.
- A transfer presented in the same cycle as clr is dropped.

## Timing
- While rst_n=0: in_ready=0, busy=0, frame_done=0, all row_in_* = 0, state=LOAD, count=0.
- After rst_n deasserts: in_ready=1 from the first clock edge onward.
- Accepting the 20th sample at edge e: busy=1 and t=0 values appear on the ports in the cycle after e. This is a 1-cycle launch latency.
- in_ready falls in the same cycle that busy rises, so the 21st sample cannot be accepted back-to-back.
- frame_done goes high in the last RUN cycle (t = RUN_LEN-1 = 107). busy is also still 1 in that cycle.
- In the following cycle: busy=0 and in_ready=1.
- Minimum frame period = 20 + RUN_LEN = 128 cycles.
- in_valid gaps in LOAD stall the count without loss. in_valid held during RUN has no effect.
- If rst_n is asserted mid-RUN, all outputs go to their reset values immediately (asynchronously).

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → in_ready=0, all row ports 0. After release, in_ready=1 and no sample is captured during reset.
- Nominal frame: stream H[j][k] = (10*j + k) + j(−(10*j + k)) with in_valid continuous.
  - Launch 1 cycle after the 20th transfer.
  - row_in_1 = 0..4 at t=0..4; row_in_2 = 10..14 at t=1..5; row_in_3 = 20..24 at t=21..25; row_in_4 = 30..34 at t=41..45.
  - Flags are high exactly at t=0, 2 and 23.
  - frame_done pulses once at t=107.
- Sign and width: all samples = −8192 + j8191 → values are reproduced bit-exact on every window cycle.
- Throttled input: in_valid toggles 1/0 → the same schedule as the nominal frame, with launch 1 cycle after the 20th transfer.
- Abort: assert clr at t=30 of a run → the next cycle has busy=0, in_ready=1 and all ports 0, with no frame_done. A new 20-sample frame then runs normally.
- Back-to-back frames: two frames with in_valid held 1 → the second frame's first transfer occurs the cycle after frame_done, and it launches 128 cycles after the first launch.
